// File: rtl/divider_8by4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor.
// One quotient bit per cycle, valid/ready on both sides.
module divider_8by4 (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  input  logic [7:0] io_dividend,
  input  logic [3:0] io_divisor,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic [7:0] io_quotient,
  output logic [3:0] io_remainder,
  output logic       io_divByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state, w_state_n;
  logic [7:0] r_q, w_q_n;
  logic [3:0] r_d, w_d_n;
  logic [3:0] r_r, w_r_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic       r_dbz, w_dbz_n;

  logic [4:0] w_t;
  logic       w_ge;
  logic [3:0] w_diff;

  // R stays below D, so the 4 low bits of T-D are exact
  assign w_t    = {r_r, r_q[7]};
  assign w_ge   = (w_t >= {1'b0, r_d});
  assign w_diff = w_t[3:0] - r_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_d     <= w_d_n;
      r_r     <= w_r_n;
      r_cnt   <= w_cnt_n;
      r_dbz   <= w_dbz_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_d_n     = r_d;
    w_r_n     = r_r;
    w_cnt_n   = r_cnt;
    w_dbz_n   = r_dbz;
    unique case (r_state)
      IDLE: begin
        if (io_in_valid) begin
          w_q_n   = io_dividend;
          w_d_n   = io_divisor;
          w_r_n   = '0;
          w_cnt_n = '0;
          if (io_divisor == 4'd0) begin
            w_q_n     = 8'hFF;
            w_r_n     = io_dividend[3:0];
            w_dbz_n   = 1'b1;
            w_state_n = DONE;
          end else begin
            w_dbz_n   = 1'b0;
            w_state_n = BUSY;
          end
        end
      end
      BUSY: begin
        w_q_n = {r_q[6:0], w_ge};
        w_r_n = w_ge ? w_diff : w_t[3:0];
        if (r_cnt == 3'd7) begin
          w_state_n = DONE;
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign io_in_ready  = (r_state == IDLE);
  assign io_out_valid = (r_state == DONE);
  assign io_quotient  = r_q;
  assign io_remainder = r_r;
  assign io_divByZero = r_dbz;

endmodule

// File: tb/tb_divider_8by4.sv
// Randomized and directed bench for divider_8by4.
// Results are checked against plain integer division.
module tb_divider_8by4;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_dividend;
  logic [3:0] io_divisor;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_quotient;
  logic [3:0] io_remainder;
  logic       io_divByZero;

  int n_vec;
  int n_bad;

  divider_8by4 dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_dividend (io_dividend),
    .io_divisor  (io_divisor),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_quotient (io_quotient),
    .io_remainder(io_remainder),
    .io_divByZero(io_divByZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one operand pair and wait until the result is valid.
  task automatic start_op(input int a, input int b, output int lat);
    int n;
    n = 0;
    while (!io_in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", io_in_ready, 1);
    io_in_valid = 1'b1;
    io_dividend = a[7:0];
    io_divisor  = b[3:0];
    tick();
    io_in_valid = 1'b0;
    io_dividend = 8'($urandom);
    io_divisor  = 4'($urandom);
    lat = 1;
    while (!io_out_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int eq, er, ez;
    if (b == 0) begin
      eq = 255;
      er = a % 16;
      ez = 1;
    end else begin
      eq = a / b;
      er = a % b;
      ez = 0;
    end
    chk({tag, "_valid"}, io_out_valid, 1);
    chk({tag, "_q"}, io_quotient, eq);
    chk({tag, "_r"}, io_remainder, er);
    chk({tag, "_dbz"}, io_divByZero, ez);
  endtask

  task automatic consume(input string tag);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, io_out_valid, 0);
    chk({tag, "_in_ready_rise"}, io_in_ready, 1);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int lat;
    start_op(a, b, lat);
    chk({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
    check_result(tag, a, b);
    consume(tag);
  endtask

  initial begin
    int lat;
    int a, b;
    logic [7:0] hq;
    logic [3:0] hr;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_dividend = '0;
    io_divisor = '0;
    io_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", io_in_ready, 1);
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_q", io_quotient, 0);
    chk("rst_r", io_remainder, 0);
    chk("rst_dbz", io_divByZero, 0);

    run_op("mul_inv", 143, 11);
    run_op("d200_7", 200, 7);
    run_op("d255_1", 255, 1);
    run_op("d255_15", 255, 15);
    run_op("d5_9", 5, 9);
    run_op("dbz", 8'hA7, 0);
    run_op("d0_1", 0, 1);

    // back-pressure: result must hold while new operands are offered
    start_op(77, 6, lat);
    check_result("bp", 77, 6);
    hq = io_quotient;
    hr = io_remainder;
    for (int i = 0; i < 5; i++) begin
      io_in_valid = 1'b1;
      io_dividend = 8'($urandom);
      io_divisor  = 4'($urandom);
      tick();
      chk("bp_hold_valid", io_out_valid, 1);
      chk("bp_hold_in_ready", io_in_ready, 0);
      chk("bp_hold_q", io_quotient, 77 / 6);
      chk("bp_hold_r", io_remainder, 77 % 6);
    end
    chk("bp_q_stable", io_quotient, hq);
    chk("bp_r_stable", io_remainder, hr);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    io_in_valid  = 1'b0;
    chk("bp_no_bubble_accept", io_in_ready, 1);
    chk("bp_valid_drop", io_out_valid, 0);
    run_op("bp_next", 9, 2);

    // reset during the 4th BUSY cycle
    io_in_valid = 1'b1;
    io_dividend = 8'd250;
    io_divisor  = 4'd3;
    tick();
    io_in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", io_in_ready, 1);
    chk("mid_rst_valid", io_out_valid, 0);
    chk("mid_rst_q", io_quotient, 0);
    chk("mid_rst_r", io_remainder, 0);
    chk("mid_rst_dbz", io_divByZero, 0);
    run_op("after_rst", 100, 3);

    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 0 : int'($urandom_range(0, 15));
      run_op("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/divider_8by4.md
# divider_8by4

Sequential restoring divider: an 8-bit dividend divided by a 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder. It is the inverse companion of the combinational 4x4 array multiplier. An 8-bit product divided by one 4-bit operand recovers the other operand with zero remainder. The block sits in the CombinationalCircuit arithmetic group and uses a valid/ready handshake on both input and output. Its core datapath is an iterative shift-subtract loop, one quotient bit per cycle.

## Interface
- Parameters: none; widths are fixed at 8-bit dividend, 4-bit divisor, 8-bit quotient, 4-bit remainder.
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  1  operands on io_dividend/io_divisor are valid
- io_in_ready  output  1  block can accept operands (high only in IDLE)
- io_dividend  input  8  unsigned dividend
- io_divisor  input  4  unsigned divisor
- io_out_valid  output  1  result registers hold a completed result
- io_out_ready  input  1  consumer accepts the result
- io_quotient  output  8  unsigned quotient, registered
- io_remainder  output  4  unsigned remainder, registered
- io_divByZero  output  1  result was produced with divisor == 0

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid (accept), latch the dividend into the quotient/shift register Q[7:0] and the divisor into D[3:0]. Clear partial remainder R[4:0] and iteration counter cnt[2:0].
  - If divisor==0, go to DONE directly with Q=8'hFF, remainder=dividend[3:0], divByZero=1.
  - Otherwise go to BUSY with divByZero=0.
- BUSY: each cycle performs one restoring step.
  - Form T = {R[3:0], Q[7]} (5 bits).
  - Shift Q left by one.
  - If T >= {1'b0,D}: R = T − D and Q[0] = 1. Otherwise R = T and Q[0] = 0.
  - After the step with cnt==7, go to DONE. Otherwise increment cnt.
- DONE:
  - io_out_valid=1. io_quotient=Q and io_remainder=R[3:0] are held stable.
  - On io_out_ready, go to IDLE.
  - No new operands are accepted in DONE, including in the cycle the result is consumed; a one-cycle bubble is required.
- Width rules:
  - R never exceeds 5 bits; after any subtract, R < D ≤ 15, so R[4] is always 0 at the end of a step.
  - The remainder always satisfies remainder < divisor for non-zero divisors.
- In IDLE, io_quotient and io_remainder retain the last result and are don't-care; only io_out_valid qualifies them.
- io_in_valid, io_dividend and io_divisor are ignored outside IDLE. Operands are sampled only at accept.

## Timing
- Reset values:
  - State=IDLE.
  - io_in_ready=1 from the first cycle after reset.
  - io_out_valid=0, io_quotient=0, io_remainder=0, io_divByZero=0, cnt=0.
- Reset asserted in any state, including mid-BUSY or DONE, aborts the operation and forces the reset values on the next edge. The in-flight result is discarded.
- Latency, non-zero divisor: accept at edge T, BUSY for 8 cycles, io_out_valid=1 from T+9. Throughput is at most one result per 10 cycles with io_out_ready held high.
- Latency, divide-by-zero: accept at edge T, io_out_valid=1 from T+1.
- io_out_valid stays high, with outputs stable, until the cycle io_out_ready=1. It drops on the following edge. io_in_ready rises on that same edge.
- All outputs are driven from registers; there is no combinational path from input to output.

## Test plan
- Multiplier inverse: dividend=143, divisor=11 -> quotient=13, remainder=0, divByZero=0, io_out_valid exactly 9 cycles after accept.
- General case: 200/7 -> quotient=28, remainder=4. Also 255/1 -> 255 r0, 255/15 -> 17 r0, 5/9 -> 0 r5.
- Divide-by-zero: dividend=0xA7, divisor=0 -> quotient=0xFF, remainder=0x7, divByZero=1, io_out_valid 1 cycle after accept.
- Back-pressure: hold io_out_ready=0 for 5 cycles after completion -> outputs and io_out_valid stable, io_in_ready=0, new io_in_valid ignored. Raise io_out_ready -> IDLE next cycle, then the next operand pair is accepted.
- Reset mid-operation: assert reset on the 4th BUSY cycle -> next cycle IDLE, io_out_valid=0, all outputs 0. A following 100/3 gives 33 r1.
- Exhaustive sweep: all 256×16 operand pairs back-to-back with io_out_ready=1 -> every result matches a reference model: Q=a/b, R=a%b for b≠0, and Q=0xFF, R=a[3:0], divByZero=1 for b=0.
